// File: rtl/boot_image_reader.sv
// boot_image_reader
// -----------------
// AXI4 read master that reads a loaded program image back out of memory.
// Each word is streamed out and added into a 32-bit checksum, which is then
// compared with an expected value. On a match the core reset is released
// after a fixed delay.
//
// Optional feature macro: BOOT_READER_SWAP_EN
//   defined     -> received words are byte-swapped before use
//   not defined -> m_rdata is used unmodified
//
// Ports:
//   aclk, areset            clock, synchronous active-high reset
//   start                   one-cycle pulse, begins a read-back
//   num_words, exp_sum      word count and expected checksum, sampled on start
//   m_ar*                   AXI4 read-address channel (INCR, 4-byte beats)
//   m_r*                    AXI4 read-data channel
//   word_valid/addr/data    registered per-word stream output
//   busy, done              run status (done is a one-cycle pulse)
//   pass, err               sticky result flags, cleared on start
//   sum                     running checksum
//   cpu_resetn              core reset, active-low; high only in RUN
module boot_image_reader #(
  parameter logic [31:0] P_ADDR_ENTRY    = 32'h0,
  parameter int unsigned P_BURST_LEN     = 16,
  parameter int unsigned P_RELEASE_DELAY = 5
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        start,
  input  logic [31:0] num_words,
  input  logic [31:0] exp_sum,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic        word_valid,
  output logic [31:0] word_addr,
  output logic [31:0] word_data,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        err,
  output logic [31:0] sum,
  output logic        cpu_resetn
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_CHECK,
    S_DELAY,
    S_RUN,
    S_FAIL
  } state_t;

  localparam logic [7:0] LEN_MAX = 8'(P_BURST_LEN - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] remain_q, remain_d;
  logic [31:0] sum_q, sum_d;
  logic [31:0] exp_q, exp_d;
  logic        err_q, err_d;
  logic        pass_q, pass_d;
  logic        busy_q, busy_d;
  logic [7:0]  beat_q, beat_d;
  logic [7:0]  burst_q, burst_d;
  logic [31:0] dly_q, dly_d;
  logic        word_valid_q, word_valid_d;
  logic [31:0] word_addr_q, word_addr_d;
  logic [31:0] word_data_q, word_data_d;

  logic [31:0] rword;
  logic [31:0] remain_m1;
  logic [31:0] bound_m1;
  logic [7:0]  len_calc;
  logic        last_beat;
  logic        check_ok;

`ifdef BOOT_READER_SWAP_EN
  assign rword = {m_rdata[7:0], m_rdata[15:8], m_rdata[23:16], m_rdata[31:24]};
`else
  assign rword = m_rdata;
`endif

  // Burst length minus one: the smallest of the configured cap, the words
  // still to read and the words left before the next 4 KB boundary. The
  // inverted word index inside the page is exactly "words to boundary - 1".
  always_comb begin
    remain_m1 = remain_q - 32'd1;
    bound_m1  = {22'd0, ~addr_q[11:2]};
    len_calc  = LEN_MAX;
    if (bound_m1 < {24'd0, len_calc}) len_calc = ~addr_q[9:2];
    if (remain_m1 < {24'd0, len_calc}) len_calc = remain_m1[7:0];
  end

  assign last_beat = (beat_q == burst_q);
  assign check_ok  = (sum_q == exp_q) && !err_q;

  // Next-state logic. Beats are always counted to the computed burst length;
  // the slave's rlast is only compared against it to flag protocol errors.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remain_d     = remain_q;
    sum_d        = sum_q;
    exp_d        = exp_q;
    err_d        = err_q;
    pass_d       = pass_q;
    busy_d       = busy_q;
    beat_d       = beat_q;
    burst_d      = burst_q;
    dly_d        = dly_q;
    word_valid_d = 1'b0;
    word_addr_d  = word_addr_q;
    word_data_d  = word_data_q;

    case (state_q)
      S_IDLE, S_FAIL: begin
        if (start) begin
          exp_d    = exp_sum;
          addr_d   = P_ADDR_ENTRY;
          remain_d = num_words;
          sum_d    = 32'd0;
          pass_d   = 1'b0;
          err_d    = 1'b0;
          busy_d   = 1'b1;
          state_d  = (num_words == 32'd0) ? S_CHECK : S_ADDR;
        end
      end

      S_ADDR: begin
        if (m_arready) begin
          burst_d = len_calc;
          beat_d  = 8'd0;
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (m_rvalid) begin
          sum_d        = sum_q + rword;
          addr_d       = addr_q + 32'd4;
          remain_d     = remain_m1;
          beat_d       = beat_q + 8'd1;
          word_valid_d = 1'b1;
          word_addr_d  = addr_q;
          word_data_d  = rword;
          if ((m_rresp != 2'b00) || (m_rlast != last_beat)) err_d = 1'b1;
          if (last_beat) state_d = (remain_q == 32'd1) ? S_CHECK : S_ADDR;
        end
      end

      S_CHECK: begin
        pass_d = check_ok;
        busy_d = 1'b0;
        if (!check_ok) begin
          state_d = S_FAIL;
        end else if (P_RELEASE_DELAY <= 1) begin
          state_d = S_RUN;
        end else begin
          dly_d   = 32'd1;
          state_d = S_DELAY;
        end
      end

      // The CHECK cycle counts as the first delay cycle, so RUN is entered
      // exactly P_RELEASE_DELAY cycles after done.
      S_DELAY: begin
        if (dly_q >= 32'(P_RELEASE_DELAY - 1)) state_d = S_RUN;
        else dly_d = dly_q + 32'd1;
      end

      S_RUN: begin
        state_d = S_RUN;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= S_IDLE;
      addr_q       <= 32'd0;
      remain_q     <= 32'd0;
      sum_q        <= 32'd0;
      exp_q        <= 32'd0;
      err_q        <= 1'b0;
      pass_q       <= 1'b0;
      busy_q       <= 1'b0;
      beat_q       <= 8'd0;
      burst_q      <= 8'd0;
      dly_q        <= 32'd0;
      word_valid_q <= 1'b0;
      word_addr_q  <= 32'd0;
      word_data_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remain_q     <= remain_d;
      sum_q        <= sum_d;
      exp_q        <= exp_d;
      err_q        <= err_d;
      pass_q       <= pass_d;
      busy_q       <= busy_d;
      beat_q       <= beat_d;
      burst_q      <= burst_d;
      dly_q        <= dly_d;
      word_valid_q <= word_valid_d;
      word_addr_q  <= word_addr_d;
      word_data_q  <= word_data_d;
    end
  end

  // AR fields come straight from registers that only change on a handshake,
  // so they stay stable while arvalid waits for arready.
  assign m_araddr   = addr_q;
  assign m_arlen    = (state_q == S_ADDR) ? len_calc : 8'd0;
  assign m_arsize   = 3'b010;
  assign m_arburst  = 2'b01;
  assign m_arvalid  = (state_q == S_ADDR);
  assign m_rready   = (state_q == S_DATA);
  assign word_valid = word_valid_q;
  assign word_addr  = word_addr_q;
  assign word_data  = word_data_q;
  assign busy       = busy_q;
  assign done       = (state_q == S_CHECK);
  assign pass       = pass_q;
  assign err        = err_q;
  assign sum        = sum_q;
  assign cpu_resetn = (state_q == S_RUN);

endmodule

// File: tb/tb_boot_image_reader.sv
// Directed testbench for boot_image_reader. A behavioural AXI read slave
// serves words from a small memory image placed at the DUT base address.
module tb_boot_image_reader;

  localparam logic [31:0] BASE = 32'h0000_0FE0;

  logic        aclk;
  logic        areset;
  logic        start;
  logic [31:0] num_words;
  logic [31:0] exp_sum;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic        m_rvalid;
  logic        m_rready;
  logic        word_valid;
  logic [31:0] word_addr;
  logic [31:0] word_data;
  logic        busy;
  logic        done;
  logic        pass;
  logic        err;
  logic [31:0] sum;
  logic        cpu_resetn;

  boot_image_reader #(
    .P_ADDR_ENTRY   (BASE),
    .P_BURST_LEN    (16),
    .P_RELEASE_DELAY(5)
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .start     (start),
    .num_words (num_words),
    .exp_sum   (exp_sum),
    .m_araddr  (m_araddr),
    .m_arlen   (m_arlen),
    .m_arsize  (m_arsize),
    .m_arburst (m_arburst),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .m_rlast   (m_rlast),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready),
    .word_valid(word_valid),
    .word_addr (word_addr),
    .word_data (word_data),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err       (err),
    .sum       (sum),
    .cpu_resetn(cpu_resetn)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:63];
  logic [31:0] arAddrLog [$];
  logic [7:0]  arLenLog  [$];
  int          arDelay     = 0;
  bit          randGaps    = 1'b0;
  bit          corruptLast = 1'b0;
  int          errBeat     = -1;
  int          beatIdx     = 0;
  int          wvCount     = 0;
  logic [31:0] firstData   = 32'd0;
  logic [31:0] slvAddr;
  logic [7:0]  slvLen;

  function automatic logic [31:0] swapIf(input logic [31:0] d);
`ifdef BOOT_READER_SWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  function automatic logic [31:0] expSumOf(input int n);
    logic [31:0] s = 32'd0;
    for (int i = 0; i < n; i++) s = s + swapIf(mem[i]);
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] nw, input logic [31:0] es);
    @(negedge aclk);
    start     = 1'b1;
    num_words = nw;
    exp_sum   = es;
    @(negedge aclk);
    start     = 1'b0;
  endtask

  task automatic doReset();
    @(negedge aclk);
    areset = 1'b1;
    start  = 1'b0;
    repeat (2) @(negedge aclk);
    areset  = 1'b0;
    beatIdx = 0;
    wvCount = 0;
    arAddrLog.delete();
    arLenLog.delete();
  endtask

  task automatic waitDone(input int budget);
    for (int i = 0; i < budget && !done; i++) @(negedge aclk);
    checkOutput("doneSeen", {31'd0, done}, 32'd1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".arvalid"}, {31'd0, m_arvalid}, 32'd0);
    checkOutput({tag, ".rready"}, {31'd0, m_rready}, 32'd0);
    checkOutput({tag, ".araddr"}, m_araddr, 32'd0);
    checkOutput({tag, ".arlen"}, {24'd0, m_arlen}, 32'd0);
    checkOutput({tag, ".wvalid"}, {31'd0, word_valid}, 32'd0);
    checkOutput({tag, ".waddr"}, word_addr, 32'd0);
    checkOutput({tag, ".wdata"}, word_data, 32'd0);
    checkOutput({tag, ".busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, ".done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, ".pass"}, {31'd0, pass}, 32'd0);
    checkOutput({tag, ".err"}, {31'd0, err}, 32'd0);
    checkOutput({tag, ".sum"}, sum, 32'd0);
    checkOutput({tag, ".cpuresetn"}, {31'd0, cpu_resetn}, 32'd0);
  endtask

  // AXI read slave: optional arready stall (with AR stability checks),
  // optional random rvalid gaps, SLVERR injection and rlast corruption.
  initial begin
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rdata   = 32'd0;
    m_rresp   = 2'b00;
    m_rlast   = 1'b0;
    forever begin
      @(negedge aclk);
      if (m_arvalid && !areset) begin
        slvAddr = m_araddr;
        slvLen  = m_arlen;
        for (int i = 0; i < arDelay; i++) begin
          @(negedge aclk);
          checkOutput("arStableValid", {31'd0, m_arvalid}, 32'd1);
          checkOutput("arStableAddr", m_araddr, slvAddr);
          checkOutput("arStableLen", {24'd0, m_arlen}, {24'd0, slvLen});
        end
        m_arready = 1'b1;
        @(negedge aclk);
        m_arready = 1'b0;
        arAddrLog.push_back(slvAddr);
        arLenLog.push_back(slvLen);
        for (int b = 0; b <= int'(slvLen); b++) begin
          if (randGaps) begin
            while ($urandom_range(0, 1) == 1) begin
              m_rvalid = 1'b0;
              @(negedge aclk);
            end
          end
          m_rvalid = 1'b1;
          m_rdata  = mem[((slvAddr - BASE) >> 2) + 32'(b)];
          m_rresp  = (beatIdx == errBeat) ? 2'b10 : 2'b00;
          m_rlast  = (b == int'(slvLen)) ^ (corruptLast && b == 0);
          beatIdx++;
          @(negedge aclk);
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        m_rresp  = 2'b00;
      end
    end
  end

  // Word stream monitor: every run starts at BASE, so word n must carry
  // address BASE+4n and the (optionally swapped) memory word n.
  initial begin
    forever begin
      @(negedge aclk);
      if (word_valid) begin
        if (wvCount == 0) firstData = word_data;
        checkOutput("wordAddr", word_addr, BASE + 32'(wvCount * 4));
        checkOutput("wordData", word_data, swapIf(mem[wvCount]));
        wvCount++;
      end
    end
  end

  logic [31:0] expAddr [4];
  logic [7:0]  expLen  [4];

  initial begin
    areset    = 1'b1;
    start     = 1'b0;
    num_words = 32'd0;
    exp_sum   = 32'd0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    expAddr = '{32'h0FE0, 32'h1000, 32'h1040, 32'h1080};
    expLen  = '{8'd7, 8'd15, 8'd15, 8'd0};

    repeat (3) @(negedge aclk);
    checkResetValues("reset");
    checkOutput("arSize", {29'd0, m_arsize}, 32'd2);
    checkOutput("arBurst", {30'd0, m_arburst}, 32'd1);
    areset = 1'b0;

    // Four-word image, one burst, pass and timed release.
    mem[0] = 32'h11223344;
    mem[1] = 32'h55667788;
    mem[2] = 32'h99AABBCC;
    mem[3] = 32'hDDEEFF00;
    applyStimulus(32'd4, expSumOf(4));
    checkOutput("A.busy", {31'd0, busy}, 32'd1);
    checkOutput("A.arvalid", {31'd0, m_arvalid}, 32'd1);
    checkOutput("A.araddr", m_araddr, BASE);
    checkOutput("A.arlen", {24'd0, m_arlen}, 32'd3);
    waitDone(200);
    checkOutput("A.sum", sum, expSumOf(4));
    for (int i = 1; i <= 5; i++) begin
      @(negedge aclk);
      if (i == 1) begin
        checkOutput("A.pass", {31'd0, pass}, 32'd1);
        checkOutput("A.err", {31'd0, err}, 32'd0);
        checkOutput("A.busyLow", {31'd0, busy}, 32'd0);
        checkOutput("A.words", 32'(wvCount), 32'd4);
        checkOutput("A.arCount", 32'(arAddrLog.size()), 32'd1);
        checkOutput("A.firstWord", firstData, swapIf(32'h11223344));
      end
      checkOutput("A.release", {31'd0, cpu_resetn}, (i == 5) ? 32'd1 : 32'd0);
    end
    applyStimulus(32'd4, 32'd0);
    checkOutput("A.runIgnoresStart", {31'd0, busy}, 32'd0);
    checkOutput("A.runNoAr", {31'd0, m_arvalid}, 32'd0);
    checkOutput("A.runHolds", {31'd0, cpu_resetn}, 32'd1);

    // 41 words from 0xFE0: bursts split at the 4 KB boundary and the cap.
    doReset();
    for (int i = 0; i < 64; i++) mem[i] = (32'h01020304 * 32'(i + 1)) ^ 32'hC3A50F00;
    applyStimulus(32'd41, expSumOf(41));
    waitDone(400);
    checkOutput("B.sum", sum, expSumOf(41));
    @(negedge aclk);
    checkOutput("B.arCount", 32'(arAddrLog.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("B.arAddr", (i < arAddrLog.size()) ? arAddrLog[i] : 32'hDEAD_BEEF, expAddr[i]);
      checkOutput("B.arLen", (i < arLenLog.size()) ? {24'd0, arLenLog[i]} : 32'hDEAD_BEEF, {24'd0, expLen[i]});
    end
    checkOutput("B.words", 32'(wvCount), 32'd41);
    checkOutput("B.pass", {31'd0, pass}, 32'd1);

    // SLVERR on beat 2 of 4: all beats taken, err set, stays in reset.
    doReset();
    errBeat = 1;
    applyStimulus(32'd4, expSumOf(4));
    waitDone(200);
    @(negedge aclk);
    errBeat = -1;
    checkOutput("C.err", {31'd0, err}, 32'd1);
    checkOutput("C.pass", {31'd0, pass}, 32'd0);
    checkOutput("C.words", 32'(wvCount), 32'd4);
    repeat (8) @(negedge aclk);
    checkOutput("C.holdReset", {31'd0, cpu_resetn}, 32'd0);
    checkOutput("C.idleBusy", {31'd0, busy}, 32'd0);

    // From FAIL: wrong sum fails cleanly, then the right sum releases.
    beatIdx = 0;
    wvCount = 0;
    applyStimulus(32'd4, expSumOf(4) + 32'd1);
    waitDone(200);
    @(negedge aclk);
    checkOutput("D.pass", {31'd0, pass}, 32'd0);
    checkOutput("D.errClear", {31'd0, err}, 32'd0);
    checkOutput("D.sum", sum, expSumOf(4));
    repeat (8) @(negedge aclk);
    checkOutput("D.holdReset", {31'd0, cpu_resetn}, 32'd0);
    wvCount = 0;
    applyStimulus(32'd4, expSumOf(4));
    waitDone(200);
    for (int i = 1; i <= 5; i++) begin
      @(negedge aclk);
      if (i == 1) checkOutput("D.retryPass", {31'd0, pass}, 32'd1);
      checkOutput("D.release", {31'd0, cpu_resetn}, (i == 5) ? 32'd1 : 32'd0);
    end

    // Zero-length image: done straight after start, no AR.
    doReset();
    applyStimulus(32'd0, 32'd0);
    checkOutput("E.done", {31'd0, done}, 32'd1);
    checkOutput("E.noAr", {31'd0, m_arvalid}, 32'd0);
    @(negedge aclk);
    checkOutput("E.pass", {31'd0, pass}, 32'd1);
    checkOutput("E.donePulse", {31'd0, done}, 32'd0);
    checkOutput("E.arCount", 32'(arAddrLog.size()), 32'd0);

    // Early rlast on beat 0: flagged, burst still counted to four beats.
    doReset();
    corruptLast = 1'b1;
    applyStimulus(32'd4, expSumOf(4));
    waitDone(200);
    @(negedge aclk);
    corruptLast = 1'b0;
    checkOutput("F.err", {31'd0, err}, 32'd1);
    checkOutput("F.pass", {31'd0, pass}, 32'd0);
    checkOutput("F.words", 32'(wvCount), 32'd4);

    // arready stall, random rvalid gaps, then reset in the middle of DATA.
    doReset();
    arDelay  = 10;
    randGaps = 1'b1;
    applyStimulus(32'd20, expSumOf(20));
    for (int i = 0; i < 600 && wvCount < 10; i++) @(negedge aclk);
    checkOutput("G.midData", {31'd0, m_rready}, 32'd1);
    areset = 1'b1;
    start  = 1'b1;
    num_words = 32'd4;
    @(negedge aclk);
    checkResetValues("G.afterReset");
    @(negedge aclk);
    checkOutput("G.resetWinsBusy", {31'd0, busy}, 32'd0);
    checkOutput("G.resetWinsAr", {31'd0, m_arvalid}, 32'd0);
    start = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
